// File: rtl/seq_mult4_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller state encoding and the operand width legality check.
package seq_mult4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 8;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/seq_mult4_adder.sv
// Ripple-carry partial-product adder: one full-adder cell per bit,
// chained through the carry.
module seq_mult4_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_o[i]     = x_i[i] ^ y_i[i] ^ carry[i];
        assign carry[i + 1] = (x_i[i] & y_i[i]) | (carry[i] & (x_i[i] ^ y_i[i]));
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/seq_mult4.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One partial product per cycle; start/busy/done handshake frames each operation.
module seq_mult4
    import seq_mult4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("seq_mult4: WIDTH must be within 2..8");
    end

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 carry;

    assign addend = q_q[0] ? m_q : '0;

    seq_mult4_adder #(.WIDTH(WIDTH)) u_adder (
        .x_i    (acc_q),
        .y_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (carry)
    );

    // The add carry is shifted straight into A's MSB in the same edge, so the
    // carry flop would always hold zero afterwards; it is not kept separately.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    m_d     = a_i;
                    q_d     = b_i;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = {carry, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = {acc_d, q_d};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy_o    = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_mult4.sv
// Self-checking bench for seq_mult4: timeline model of accepted starts and
// completions compared every cycle, plus directed literal expectations.
module tb_seq_mult4;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult4 #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy),
        .done_o    (done),
        .product_o (product)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: an accepted start at edge e finishes at edge e+W with a*b and
    // frees the block for a new start at edge e+W+2.
    int             edge_n        = 0;
    bit             mvalid        = 1'b0;
    bit             active        = 1'b0;
    int             done_edge     = -100;
    int             last_done     = -100;
    int             free_at       = 0;
    logic [2*W-1:0] pend_prod     = '0;
    logic [2*W-1:0] exp_prod      = '0;
    int             starts_seen   = 0;
    int             dones_seen    = 0;

    always begin
        @(posedge clk);
        edge_n++;
        if (reset) begin
            mvalid    = 1'b1;
            active    = 1'b0;
            exp_prod  = '0;
            last_done = -100;
            free_at   = edge_n + 1;
        end else if (mvalid) begin
            if (active && edge_n == done_edge) begin
                exp_prod  = pend_prod;
                active    = 1'b0;
                last_done = edge_n;
            end else if (!active && edge_n >= free_at && start) begin
                active    = 1'b1;
                done_edge = edge_n + W;
                pend_prod = a * b;
                free_at   = edge_n + W + 2;
                starts_seen++;
            end
        end
        #1;
        if (mvalid) begin
            chk("busy", 32'(busy), 32'(active));
            chk("done", 32'(done), 32'(last_done == edge_n));
            chk("product", 32'(product), 32'(exp_prod));
            if (done === 1'b1) dones_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int busy_n, output int done_n);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_n++;
            @(negedge clk);
        end
    endtask

    typedef struct { int x; int y; int p; } vec_t;
    vec_t dir[5] = '{'{7, 3, 21}, '{15, 15, 225}, '{0, 9, 0}, '{9, 0, 0}, '{1, 15, 15}};

    initial begin
        int bn, dn, cnt;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick(2);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_product", 32'(product), 0);
        reset = 1'b0;

        foreach (dir[i]) begin
            run_op(W'(dir[i].x), W'(dir[i].y), bn, dn);
            chk("dir_product", 32'(product), 32'(dir[i].p));
            chk("dir_busy_cycles", 32'(bn), W);
            chk("dir_done_pulses", 32'(dn), 1);
        end

        for (int i = 0; i < 256; i++) begin
            logic [7:0] pair;
            pair  = 8'(i);
            start = 1'b1;
            a     = pair[7:4];
            b     = pair[3:0];
            tick(1);
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            tick(4);
            chk("sweep_product", 32'(product), 32'(pair[7:4]) * 32'(pair[3:0]));
            tick(1);
        end

        start = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick(1);
            if (done === 1'b1) cnt++;
        end
        start = 1'b0;
        tick(W + 2);
        chk("continuous_done_count", 32'(cnt), 5);
        chk("starts_equal_dones", 32'(dones_seen), 32'(starts_seen));

        start = 1'b1;
        a     = 4'd12;
        b     = 4'd11;
        tick(1);
        start = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_product", 32'(product), 0);
        reset = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) cnt++;
            tick(1);
        end
        chk("abort_no_done", 32'(cnt), 0);
        run_op(4'd5, 4'd5, bn, dn);
        chk("after_abort_product", 32'(product), 25);
        chk("after_abort_done", 32'(dn), 1);

        reset = 1'b1;
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd4;
        tick(1);
        chk("reset_start_busy", 32'(busy), 0);
        reset = 1'b0;
        start = 1'b0;
        run_op(4'd3, 4'd4, bn, dn);
        chk("reset_start_next_product", 32'(product), 12);
        chk("reset_start_next_done", 32'(dn), 1);

        run_op(4'd7, 4'd3, bn, dn);
        for (int i = 0; i < 10; i++) begin
            chk("hold_product", 32'(product), 21);
            tick(1);
        end
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd2;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold_until_done", 32'(product), 21);
            tick(1);
        end
        chk("hold_new_product", 32'(product), 4);

        for (int i = 0; i < 400; i++) begin
            start = ($urandom % 3) == 0;
            reset = ($urandom % 50) == 0;
            a     = W'($urandom);
            b     = W'($urandom);
            tick(1);
        end
        reset = 1'b0;
        start = 1'b0;
        tick(W + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
